dp_arbiter: RTL and testbench
=============================

DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width in bits.
REQ-002 Parameter TIMEOUT_CYC, default 16: watchdog limit in WAIT cycles (used only when DP_TIMEOUT_EN is defined).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester request lines; bit i = requester i.
REQ-006 req_data  input  4*DATA_W  per-requester operand; slice i = bits [i*DATA_W +: DATA_W].
REQ-007 gnt  output  4  one-hot grant to the requester currently owning the datapath.
REQ-008 dp_start  output  1  one-cycle pulse that launches one datapath run.
REQ-009 dp_operand  output  DATA_W  operand presented to the datapath; stable from ISSUE through RESP.
REQ-010 dp_done  input  1  datapath completion pulse.
REQ-011 dp_result  input  DATA_W  datapath result; valid in the cycle dp_done=1.
REQ-012 rsp_valid  output  4  one-hot, one-cycle response strobe to the granted requester.
REQ-013 rsp_data  output  DATA_W  response data; valid while any rsp_valid bit is 1.
REQ-014 busy  output  1  1 whenever the state is not IDLE.
REQ-015 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT and RESP, held in registered state; all outputs SHALL be registered or decoded from registered state.
REQ-017 IDLE: if req!=0, the block SHALL pick a winner round-robin, searching from last+1 upward modulo 4 (last = most recently served index); it SHALL register gnt to one-hot(winner), register dp_operand from that slice and go to ISSUE; if req==0 it SHALL stay in IDLE.
REQ-018 ISSUE: dp_start SHALL be 1 for exactly this cycle, and the next state SHALL be WAIT; dp_done SHALL be ignored in ISSUE.
REQ-019 WAIT: on dp_done=1 the block SHALL capture dp_result into rsp_data and go to RESP; otherwise it SHALL stay in WAIT.
REQ-020 RESP: rsp_valid SHALL equal gnt for this single cycle, last SHALL be updated to the winner index, and the next state SHALL be IDLE, where gnt clears to 0.
REQ-021 Latency: a request seen in IDLE at cycle N SHALL produce dp_start at N+1; dp_done at cycle M SHALL produce rsp_valid at M+1, with IDLE at M+2 and the earliest next dp_start at M+3.
REQ-022 A requester deasserting req after grant SHALL NOT abort the run; the response SHALL still be delivered. A new req from any requester during ISSUE, WAIT or RESP SHALL be held off until IDLE.
REQ-023 Simultaneous requests SHALL yield exactly one grant; a continuously requesting index SHALL be served within 4 grants.
REQ-024 The gnt and rsp_valid outputs SHALL never have more than one bit set; dp_start SHALL never be 1 outside ISSUE.

Reset
REQ-025 While rst=0 at a rising edge: state SHALL be IDLE, gnt=0, dp_start=0, dp_operand=0, rsp_valid=0, rsp_data=0, busy=0, timeout_err=0, watchdog count=0, and last=3, so that requester 0 has first priority.
REQ-026 Reset asserted mid-operation SHALL abandon the run with no rsp_valid pulse; a later dp_done SHALL be ignored in IDLE.

Configuration
REQ-027 With DP_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; if dp_done is still absent after TIMEOUT_CYC WAIT cycles, the FSM SHALL go to RESP with rsp_data set to all ones and set timeout_err=1 until reset. The counter SHALL clear on entry to WAIT.
REQ-028 Without DP_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter logic SHALL be present, and timeout_err SHALL be tied to 0.

Verification
REQ-029 After reset, req=4'b0001 with slice0=8'h3C, dp_done two cycles after dp_start with dp_result=8'hA5 -> gnt=4'b0001, dp_start one cycle, dp_operand=8'h3C, rsp_valid=4'b0001 and rsp_data=8'hA5 one cycle after dp_done.
REQ-030 req=4'b1111 held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3 with exactly one dp_start per transaction.
REQ-031 req0 dropped during WAIT -> rsp_valid=4'b0001 is still issued; the req1 request raised in WAIT is granted only after IDLE.
REQ-032 rst=0 pulsed during WAIT, followed by a dp_done pulse -> all outputs at reset values, no rsp_valid, next grant goes to req0.
REQ-033 With DP_TIMEOUT_EN and TIMEOUT_CYC=16, dp_done never asserted -> rsp_valid after 16 WAIT cycles, rsp_data=8'hFF, timeout_err=1 held until reset; without the macro -> busy stays 1 and timeout_err=0.

Source files
------------

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one datapath between 4 requesters; optional watchdog under DP_TIMEOUT_EN.
// Latency: req in IDLE -> dp_start next cycle; dp_done -> rsp_valid next cycle.
// Backpressure: new requests are held off until IDLE.
module dp_arbiter #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          gnt,
  output logic                dp_start,
  output logic [DATA_W-1:0]   dp_operand,
  input  logic                dp_done,
  input  logic [DATA_W-1:0]   dp_result,
  output logic [3:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] last_q;
  logic [1:0] gnt_idx_q;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       win_vld;
  logic       wd_expire;

  // Search starts just past the most recently served requester.
  always_comb begin
    win_idx = last_q;
    win_vld = 1'b0;
    cand    = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

`ifdef DP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_q;

  // Fires on the last permitted WAIT cycle when dp_done has not shown up.
  assign wd_expire = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (!rst) begin
      wd_cnt_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        wd_cnt_q <= '0;
      end else if (state_q == WAIT && !wd_expire) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (state_q == WAIT && !dp_done && wd_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (dp_done || wd_expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt        <= '0;
      gnt_idx_q  <= '0;
      dp_operand <= '0;
      rsp_data   <= '0;
      last_q     <= 2'd3;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            gnt        <= 4'b0001 << win_idx;
            gnt_idx_q  <= win_idx;
            dp_operand <= req_data[int'(win_idx)*DATA_W +: DATA_W];
          end
        end
        WAIT: begin
          if (dp_done) begin
            rsp_data <= dp_result;
          end else if (wd_expire) begin
            rsp_data <= '1;
          end
        end
        RESP: begin
          last_q <= gnt_idx_q;
          gnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign dp_start  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? gnt : 4'b0000;

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: vector table of transactions plus hand-built abort/hold-off/watchdog sequences.
module tb_dp_arbiter;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic                clock = 1'b0;
  logic                rst;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          gnt;
  logic                dp_start;
  logic [DATA_W-1:0]   dp_operand;
  logic                dp_done;
  logic [DATA_W-1:0]   dp_result;
  logic [3:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                busy;
  logic                timeout_err;

  dp_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock(clock), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .dp_start(dp_start), .dp_operand(dp_operand),
    .dp_done(dp_done), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_op;
    logic [7:0]  result;
    int          delay;
    bit          early;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
  } sb_t;

  localparam logic [31:0] D = 32'h44332211;

  vec_t vecs[13];
  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   starts   = 0;
  int   launches = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Structural properties sampled every cycle.
  always @(negedge clock) begin
    chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    chk("rsp_onehot0", 32'($countones(rsp_valid) <= 1), 32'd1);
    chk("start_without_gnt", 32'(dp_start && (gnt == 4'b0000)), 32'd0);
    if (dp_start) starts++;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_dp_start"}, dp_start, 0);
    chk({tag, "_dp_operand"}, dp_operand, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Called at a negedge while IDLE; returns at the ISSUE negedge.
  task automatic launch(input logic [3:0] r, input logic [31:0] d, input logic [3:0] eg,
                        input logic [7:0] eop, input logic [7:0] res, input bit push);
    int n;
    req      = r;
    req_data = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dp_start && n < 20);
    launches++;
    chk("start_latency", n, 1);
    chk("gnt", gnt, eg);
    chk("operand", dp_operand, eop);
    chk("busy_issue", busy, 1);
    if (push) sb_q.push_back('{gnt: eg, data: res});
  endtask

  // Waits for the response, checks it against the scoreboard, returns at the IDLE negedge.
  task automatic wait_rsp(input int exp_lat, input logic [7:0] eop);
    int  n;
    sb_t e;
    n = 0;
    do begin
      @(negedge clock);
      dp_done = 1'b0;
      n++;
    end while (rsp_valid == 4'b0000 && n < 40);
    chk("rsp_latency", n, exp_lat);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rsp_valid", rsp_valid, e.gnt);
      chk("rsp_data", rsp_data, e.data);
    end else begin
      chk("sb_underflow", sb_q.size(), 1);
    end
    chk("operand_hold", dp_operand, eop);
    chk("start_in_resp", dp_start, 0);
    @(negedge clock);
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic respond(input int delay, input logic [7:0] res, input bit early, input logic [7:0] eop);
    if (early) begin
      dp_done   = 1'b1;
      dp_result = 8'hEE;
    end
    for (int k = 1; k <= delay; k++) begin
      @(negedge clock);
      dp_done   = (k == delay);
      dp_result = (k == delay) ? res : 8'h00;
      chk("wait_no_rsp", rsp_valid, 0);
      chk("wait_busy", busy, 1);
    end
    wait_rsp(1, eop);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 32'h0000003C, 4'b0001, 8'h3C, 8'hA5, 2, 1'b0};
    vecs[1]  = '{4'b1000, D, 4'b1000, 8'h44, 8'h5A, 1, 1'b0};
    vecs[2]  = '{4'b1111, D, 4'b0001, 8'h11, 8'h01, 1, 1'b0};
    vecs[3]  = '{4'b1111, D, 4'b0010, 8'h22, 8'h02, 3, 1'b1};
    vecs[4]  = '{4'b1111, D, 4'b0100, 8'h33, 8'h03, 2, 1'b0};
    vecs[5]  = '{4'b1111, D, 4'b1000, 8'h44, 8'h04, 1, 1'b0};
    vecs[6]  = '{4'b1111, D, 4'b0001, 8'h11, 8'h05, 4, 1'b0};
    vecs[7]  = '{4'b1111, D, 4'b0010, 8'h22, 8'h06, 1, 1'b0};
    vecs[8]  = '{4'b1111, D, 4'b0100, 8'h33, 8'h07, 2, 1'b1};
    vecs[9]  = '{4'b1111, D, 4'b1000, 8'h44, 8'h08, 1, 1'b0};
    vecs[10] = '{4'b0110, D, 4'b0010, 8'h22, 8'h80, 1, 1'b0};
    vecs[11] = '{4'b0101, D, 4'b0100, 8'h33, 8'hFF, 3, 1'b0};
    vecs[12] = '{4'b0011, D, 4'b0001, 8'h11, 8'h00, 2, 1'b0};

    rst       = 1'b0;
    req       = 4'b0000;
    req_data  = '0;
    dp_done   = 1'b0;
    dp_result = '0;
    repeat (3) @(negedge clock);
    check_reset("reset");
    rst = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].req, vecs[i].data, vecs[i].exp_gnt, vecs[i].exp_op, vecs[i].result, 1'b1);
      respond(vecs[i].delay, vecs[i].result, vecs[i].early, vecs[i].exp_op);
    end

    // Requester 0 drops its request mid-run while requester 1 asks.
    launch(4'b0001, D, 4'b0001, 8'h11, 8'h5C, 1'b1);
    @(negedge clock);
    req = 4'b0010;
    chk("drop_wait_rsp", rsp_valid, 0);
    @(negedge clock);
    chk("drop_wait_gnt", gnt, 4'b0001);
    dp_done   = 1'b1;
    dp_result = 8'h5C;
    wait_rsp(1, 8'h11);
    launch(4'b0010, D, 4'b0010, 8'h22, 8'h77, 1'b1);
    respond(1, 8'h77, 1'b0, 8'h22);

    // Reset during WAIT abandons the run; the stray dp_done must be ignored.
    launch(4'b0100, D, 4'b0100, 8'h33, 8'h00, 1'b0);
    @(negedge clock);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clock);
    rst       = 1'b1;
    dp_done   = 1'b1;
    dp_result = 8'h99;
    check_reset("abort");
    @(negedge clock);
    dp_done = 1'b0;
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_idle", busy, 0);
    @(negedge clock);
    chk("abort_no_rsp2", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    launch(4'b1111, D, 4'b0001, 8'h11, 8'h3E, 1'b1);
    respond(2, 8'h3E, 1'b0, 8'h11);

`ifdef DP_TIMEOUT_EN
    launch(4'b0001, D, 4'b0001, 8'h11, 8'hFF, 1'b1);
    wait_rsp(TIMEOUT_CYC + 1, 8'h11);
    chk("timeout_err_set", timeout_err, 1);
    launch(4'b0010, D, 4'b0010, 8'h22, 8'h42, 1'b1);
    respond(1, 8'h42, 1'b0, 8'h22);
    chk("timeout_err_sticky", timeout_err, 1);
    req = 4'b0000;
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    check_reset("wd_reset");
`else
    launch(4'b0001, D, 4'b0001, 8'h11, 8'h00, 1'b0);
    repeat (40) @(negedge clock);
    chk("nowd_busy", busy, 1);
    chk("nowd_err", timeout_err, 0);
    chk("nowd_rsp", rsp_valid, 0);
    chk("nowd_gnt", gnt, 4'b0001);
    req = 4'b0000;
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    check_reset("nowd_reset");
`endif

    chk("sb_drained", sb_q.size(), 0);
    chk("one_start_per_txn", starts, launches);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
